// File: rtl/huffman_bit_packer.sv
// Packs a serial code bitstream MSB-first into bytes and queues them in a small valid/ready FIFO.
// Optional feature: define HUFF_PACK_BITCOUNT_EN to add the saturating Bit_cnt accepted-bit counter.
module huffman_bit_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        PAD_BIT    = 1'b0
) (
    input  logic        Clk_in,
    input  logic        n_Rst,
    input  logic        Start,
    input  logic        Bit_in,
    input  logic        Bit_vld,
    input  logic        Flush,
    output logic [7:0]  Byte_out,
    output logic        Byte_vld,
    input  logic        Byte_rdy,
    output logic [2:0]  Fill,
    output logic        Overflow
`ifdef HUFF_PACK_BITCOUNT_EN
    ,
    output logic [15:0] Bit_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       acc_q;
    logic [7:0]       acc_d;
    logic [2:0]       fill_d;
    logic             push_c;
    logic [7:0]       push_byte_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pop_c;
    logic             full_c;
    logic             wr_en_c;
    logic             drop_c;
    logic [7:0]       head_d;
    logic [7:0]       byte_out_d;

    // Accumulator: accept the bit first, then let Flush pad whatever remains.
    always_comb begin
        logic [7:0] word;
        logic [2:0] fill_mid;
        acc_d       = acc_q;
        fill_d      = Fill;
        push_c      = 1'b0;
        push_byte_c = 8'h00;
        word        = acc_q;
        fill_mid    = Fill;
        if (Bit_vld) begin
            word[3'd7 - Fill] = Bit_in;
            if (Fill == 3'd7) begin
                push_c      = 1'b1;
                push_byte_c = word;
                word        = 8'h00;
                fill_mid    = 3'd0;
            end else begin
                fill_mid = Fill + 3'd1;
            end
        end
        // A byte completed by the same-cycle bit leaves fill_mid at 0, so it is never pushed twice.
        if (Flush && (fill_mid != 3'd0)) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (8 - int'(fill_mid))) begin
                    word[i] = PAD_BIT;
                end
            end
            push_c      = 1'b1;
            push_byte_c = word;
            word        = 8'h00;
            fill_mid    = 3'd0;
        end
        acc_d  = word;
        fill_d = fill_mid;
    end

    // FIFO bookkeeping; a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop_c    = Byte_vld && Byte_rdy;
        full_c   = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en_c  = push_c && (!full_c || pop_c);
        drop_c   = push_c && full_c && !pop_c;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        // The incoming byte becomes the head only when it lands in the slot being read next.
        head_d     = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? push_byte_c : mem[rd_ptr_d];
        byte_out_d = (count_d != '0) ? head_d : 8'h00;
    end

    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            acc_q    <= 8'h00;
            Fill     <= 3'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            Byte_out <= 8'h00;
            Byte_vld <= 1'b0;
            Overflow <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
        end else if (Start) begin
            acc_q    <= 8'h00;
            Fill     <= 3'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            Byte_out <= 8'h00;
            Byte_vld <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            Fill     <= fill_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            Byte_out <= byte_out_d;
            Byte_vld <= (count_d != '0);
            Overflow <= Overflow | drop_c;
            if (wr_en_c) begin
                mem[wr_ptr_q] <= push_byte_c;
            end
        end
    end

`ifdef HUFF_PACK_BITCOUNT_EN
    // Counts accepted code bits only; pad bits never reach this counter.
    always_ff @(posedge Clk_in or negedge n_Rst) begin
        if (!n_Rst) begin
            Bit_cnt <= 16'h0000;
        end else if (Start) begin
            Bit_cnt <= 16'h0000;
        end else if (Bit_vld && (Bit_cnt != 16'hFFFF)) begin
            Bit_cnt <= Bit_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer: directed scenarios plus randomized traffic against a queue model.
module tb_huffman_bit_packer;

    localparam int unsigned DEPTH = 4;
    localparam logic        PAD   = 1'b0;

    logic        Clk_in = 1'b0;
    logic        n_Rst;
    logic        Start;
    logic        Bit_in;
    logic        Bit_vld;
    logic        Flush;
    logic [7:0]  Byte_out;
    logic        Byte_vld;
    logic        Byte_rdy;
    logic [2:0]  Fill;
    logic        Overflow;
`ifdef HUFF_PACK_BITCOUNT_EN
    logic [15:0] Bit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: pending bits, queued bytes, sticky overflow, accepted-bit count.
    bit         m_bits[$];
    logic [7:0] m_fifo[$];
    bit         m_ovf;
    int         m_cnt;

    huffman_bit_packer #(.FIFO_DEPTH(DEPTH), .PAD_BIT(PAD)) dut (
        .Clk_in   (Clk_in),
        .n_Rst    (n_Rst),
        .Start    (Start),
        .Bit_in   (Bit_in),
        .Bit_vld  (Bit_vld),
        .Flush    (Flush),
        .Byte_out (Byte_out),
        .Byte_vld (Byte_vld),
        .Byte_rdy (Byte_rdy),
        .Fill     (Fill),
        .Overflow (Overflow)
`ifdef HUFF_PACK_BITCOUNT_EN
        ,
        .Bit_cnt  (Bit_cnt)
`endif
    );

    always #5 Clk_in = ~Clk_in;

    function automatic void model_clear();
        m_bits.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic v, input logic b,
                                       input logic f, input logic r);
        logic [7:0] pb;
        bit         have;
        have = 1'b0;
        pb   = {8{PAD}};
        if (s) begin
            model_clear();
            return;
        end
        if (r && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (v) begin
            m_bits.push_back(b);
            if (m_cnt < 65535) m_cnt++;
        end
        if (m_bits.size() == 8 || (f && m_bits.size() > 0)) begin
            foreach (m_bits[j]) pb[7-j] = m_bits[j];
            m_bits.delete();
            have = 1'b1;
        end
        if (have) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(pb);
            else m_ovf = 1'b1;
        end
    endfunction

    // Drive one cycle from a falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic step(input logic s, input logic v, input logic b, input logic f, input logic r);
        Start = s; Bit_vld = v; Bit_in = b; Flush = f; Byte_rdy = r;
        @(posedge Clk_in);
        model_edge(s, v, b, f, r);
        @(negedge Clk_in);
        Start = 1'b0; Bit_vld = 1'b0; Bit_in = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_reset();
        n_Rst = 1'b0;
        #1;
        model_clear();
        checks++; if (Byte_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", Byte_vld); end
        checks++; if (Byte_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h expected 00", Byte_out); end
        checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", Fill); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", Overflow); end
`ifdef HUFF_PACK_BITCOUNT_EN
        checks++; if (Bit_cnt !== 16'd0) begin errors++; $display("FAIL reset_bitcnt: got %0d expected 0", Bit_cnt); end
`endif
        @(negedge Clk_in);
        n_Rst = 1'b1;
        @(negedge Clk_in);
    endtask

    task automatic test_start_priority();
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL start_fill: got %0d expected 0", Fill); end
        checks++; if (Byte_vld !== 1'b0) begin errors++; $display("FAIL start_vld: got %0b expected 0", Byte_vld); end
    endtask

    task automatic test_byte_b2();
        logic [7:0] pat;
        pat = 8'hB2;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            checks++; if (Fill !== 3'(i)) begin errors++; $display("FAIL b2_fill%0d: got %0d expected %0d", i, Fill, i); end
            step(0, 1, pat[7-i], 0, 1);
        end
        checks++; if (Byte_vld !== 1'b1) begin errors++; $display("FAIL b2_vld: got %0b expected 1", Byte_vld); end
        checks++; if (Byte_out !== 8'hB2) begin errors++; $display("FAIL b2_out: got %0h expected b2", Byte_out); end
        checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL b2_fill_end: got %0d expected 0", Fill); end
        step(0, 0, 0, 0, 1);
        checks++; if (Byte_vld !== 1'b0) begin errors++; $display("FAIL b2_drain: got %0b expected 0", Byte_vld); end
    endtask

    task automatic test_flush_partial();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++; if (Byte_vld !== 1'b1) begin errors++; $display("FAIL flush_vld: got %0b expected 1", Byte_vld); end
        checks++; if (Byte_out !== 8'hE0) begin errors++; $display("FAIL flush_out: got %0h expected e0", Byte_out); end
        checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", Fill); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_flush_on_full_byte();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        checks++; if (Byte_out !== 8'hFF) begin errors++; $display("FAIL ffflush_out: got %0h expected ff", Byte_out); end
        step(0, 0, 0, 0, 1);
        checks++; if (Byte_vld !== 1'b0) begin errors++; $display("FAIL ffflush_single: got vld %0b expected 0", Byte_vld); end
    endtask

    task automatic test_overflow();
        int n;
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 8 * (DEPTH + 1); k++) step(0, 1, logic'(k % 2), 0, 0);
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", Overflow); end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (Byte_vld) begin
                n++;
                checks++; if (Byte_out !== 8'h55) begin errors++; $display("FAIL ovf_data%0d: got %0h expected 55", n, Byte_out); end
            end
            step(0, 0, 0, 0, 1);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", n, DEPTH); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", Overflow); end
    endtask

    task automatic test_full_with_pop();
        int n;
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 8 * DEPTH + 7; k++) step(0, 1, logic'($urandom_range(0, 1)), 0, 0);
        step(0, 1, 1, 0, 1);
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %0b expected 0", Overflow); end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (Byte_vld) begin
                n++;
                checks++;
                if (m_fifo.size() == 0 || Byte_out !== m_fifo[0]) begin
                    errors++; $display("FAIL fullpop_data%0d: got %0h expected %0h", n, Byte_out, (m_fifo.size() > 0) ? m_fifo[0] : 8'h00);
                end
            end
            step(0, 0, 0, 0, 1);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL fullpop_count: got %0d expected %0d", n, DEPTH); end
    endtask

    task automatic test_reset_midstream();
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) step(0, 1, logic'($urandom_range(0, 1)), 0, 0);
        checks++; if (Byte_vld !== 1'b1 || Fill !== 3'd5) begin errors++; $display("FAIL mid_prestate: got vld %0b fill %0d expected 1 5", Byte_vld, Fill); end
        #2;
        n_Rst = 1'b0;
        #1;
        model_clear();
        checks++; if (Byte_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %0b expected 0", Byte_vld); end
        checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", Fill); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %0b expected 0", Overflow); end
`ifdef HUFF_PACK_BITCOUNT_EN
        checks++; if (Bit_cnt !== 16'd0) begin errors++; $display("FAIL mid_bitcnt: got %0d expected 0", Bit_cnt); end
`endif
        @(negedge Clk_in);
        n_Rst = 1'b1;
        @(negedge Clk_in);
        checks++; if (Byte_vld !== 1'b0 || Fill !== 3'd0) begin errors++; $display("FAIL mid_release: got vld %0b fill %0d expected 0 0", Byte_vld, Fill); end
    endtask

`ifdef HUFF_PACK_BITCOUNT_EN
    task automatic test_bitcnt();
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 13; k++) step(0, 1, logic'($urandom_range(0, 1)), 0, 1);
        step(0, 0, 0, 1, 1);
        checks++; if (Bit_cnt !== 16'd13) begin errors++; $display("FAIL bitcnt13: got %0d expected 13", Bit_cnt); end
    endtask
`endif

    task automatic test_random();
        int rdy_pct;
        logic s, v, b, f, r;
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0: rdy_pct = 10;
                1: rdy_pct = 60;
                default: rdy_pct = 100;
            endcase
            s = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) != 0);
            b = logic'($urandom_range(0, 1));
            f = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(1, 100) <= rdy_pct);
            step(s, v, b, f, r);
            checks++; if (Byte_vld !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_vld@%0d: got %0b expected %0b", c, Byte_vld, m_fifo.size() > 0); end
            if (m_fifo.size() > 0) begin
                checks++; if (Byte_out !== m_fifo[0]) begin errors++; $display("FAIL rnd_out@%0d: got %0h expected %0h", c, Byte_out, m_fifo[0]); end
            end
            checks++; if (Fill !== 3'(m_bits.size())) begin errors++; $display("FAIL rnd_fill@%0d: got %0d expected %0d", c, Fill, m_bits.size()); end
            checks++; if (Overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", c, Overflow, m_ovf); end
`ifdef HUFF_PACK_BITCOUNT_EN
            checks++; if (Bit_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_bitcnt@%0d: got %0d expected %0d", c, Bit_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        n_Rst = 1'b0; Start = 1'b0; Bit_in = 1'b0; Bit_vld = 1'b0; Flush = 1'b0; Byte_rdy = 1'b0;
        model_clear();
        repeat (2) @(negedge Clk_in);
        test_reset();
        test_start_priority();
        test_byte_b2();
        test_flush_partial();
        test_flush_on_full_byte();
        test_overflow();
        test_full_with_pop();
        test_reset_midstream();
`ifdef HUFF_PACK_BITCOUNT_EN
        test_bitcnt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream stage of the Huffman encoder. Accepts the encoder's serial code bitstream one bit per clock and packs it MSB-first into bytes. Completed bytes are buffered in a small FIFO and offered on a valid/ready byte interface to the storage/UART side. A flush request pads and emits a partial final byte.

## Interface

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16
- PAD_BIT, 1'b0, value used to fill unused bit positions on flush

Ports:
- Clk_in  input  1  system clock, rising edge
- n_Rst  input  1  reset; asynchronous, active-low
- Start  input  1  synchronous clear of the accumulator, FIFO and Overflow; one-cycle pulse at the start of a new encode
- Bit_in  input  1  code bit from the encoder
- Bit_vld  input  1  Bit_in is valid this cycle
- Flush  input  1  pad and emit the partial byte; one-cycle pulse
- Byte_out  output  8  FIFO head byte; the first packed bit is in bit 7
- Byte_vld  output  1  FIFO not empty
- Byte_rdy  input  1  consumer accepts Byte_out when Byte_vld=1
- Fill  output  3  number of bits currently held in the accumulator, 0..7
- Overflow  output  1  sticky; a completed byte was dropped because the FIFO was full
- Bit_cnt  output  16  total bits accepted since Start; present only with the macro

## Operation

- Reset (n_Rst=0, async): accumulator=0, Fill=0, FIFO empty with pointers at 0, Byte_vld=0, Byte_out=8'h00, Overflow=0, Bit_cnt=0.
- Start has priority over every other input in the same cycle. It performs the same clear as reset, synchronously. A bit presented with Start is discarded.
- Bit accept: when Bit_vld=1, Bit_in is written to accumulator position 7-Fill, and Fill increments.
- Byte complete: when a bit is accepted with Fill=7, the 8-bit word is pushed to the FIFO on that edge and Fill returns to 0.
- Flush with Fill>0 (after any same-cycle bit is accepted):
  - positions below the last written bit are set to PAD_BIT;
  - the byte is pushed and Fill returns to 0.
- Flush with Fill=0 after the same-cycle bit: no push. This covers a bit that completed a byte; that byte is pushed exactly once.
- Push when the FIFO is full and no pop occurs in the same cycle: the byte is dropped, Overflow is set to 1, and the FIFO is unchanged. Overflow clears only on Start or reset.
- Pop: occurs on a rising edge with Byte_vld=1 and Byte_rdy=1. The read pointer advances.
- Push and pop in the same cycle with the FIFO full: both happen; there is no overflow and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1, which distinguishes full from empty.
- Byte_out and Byte_vld are stable while Byte_vld=1 and Byte_rdy=0.

## Timing

- Latency from the edge sampling the 8th bit (or the Flush) to Byte_vld=1 is 1 cycle when the FIFO was empty. Byte_out is valid in the same cycle.
- Sustained throughput is 1 bit/clk in, and at most 1 byte per 8 clks out. A continuously ready consumer never causes overflow.
- Byte_vld falls 1 cycle after the pop of the last entry.
- Fill and Bit_cnt update on the edge that accepts the bit.
- Reset asserted mid-byte or mid-FIFO discards all content immediately. Outputs return to their reset values asynchronously.

## Configuration

- HUFF_PACK_BITCOUNT_EN defined:
  - Bit_cnt is a 16-bit counter of accepted bits, excluding pad bits.
  - It is cleared by reset and Start, and saturates at 16'hFFFF.
- HUFF_PACK_BITCOUNT_EN undefined:
  - the Bit_cnt port and counter are absent;
  - all other behaviour is identical.

## Test plan

- Reset, Start, then bits 1,0,1,1,0,0,1,0 with Bit_vld=1 and Byte_rdy=1 -> one cycle after the 8th bit, Byte_vld=1 with Byte_out=8'hB2. Fill reads 0..7 during the stream and returns to 0.
- Bits 1,1,1 then Flush, PAD_BIT=0 -> Byte_out=8'hE0 one cycle after Flush, and Fill=0.
- Flush in the same cycle as the 8th bit of 8'hFF -> exactly one byte 8'hFF, with no extra padded byte.
- Byte_rdy=0 while FIFO_DEPTH+1 bytes are completed (4'h5 pattern, 8'h55 each) -> the FIFO holds 4 entries, Overflow=1, and the 5th byte is lost. Raising Byte_rdy drains exactly 4 bytes of 8'h55.
- FIFO full, Byte_rdy=1 in the same cycle as the byte-completing bit -> no overflow, and the count stays at FIFO_DEPTH.
- Stream 13 bits, assert n_Rst=0 for 1 cycle, then release -> Byte_vld=0, Fill=0, Overflow=0, and Bit_cnt=0 when HUFF_PACK_BITCOUNT_EN is defined. With the macro and no reset, Bit_cnt=13 after 13 bits plus Flush.
